// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: shift-mode codes and the FSM state type.
// Mode 11 is a rotate-right only when ITER_SHIFT_ROTATE_EN is defined; otherwise it is SRL.
package shift_pkg;

  localparam logic [1:0] SHIFT_SLL  = 2'b00;
  localparam logic [1:0] SHIFT_SRL  = 2'b01;
  localparam logic [1:0] SHIFT_SRA  = 2'b10;
  localparam logic [1:0] SHIFT_ROTR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts i_data by i_k (0..STEP) in the given mode.
// The rotate path exists only when ITER_SHIFT_ROTATE_EN is defined; otherwise mode 11 is SRL.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int K_W  = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_mode,
  input  logic [K_W-1:0]   i_k,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data >> i_k;
    case (i_mode)
      SHIFT_SLL: o_data = i_data << i_k;
      SHIFT_SRL: o_data = i_data >> i_k;
      SHIFT_SRA: o_data = $unsigned($signed(i_data) >>> i_k);
`ifdef ITER_SHIFT_ROTATE_EN
      // Shifting the doubled word right wraps the low bits into the top.
      SHIFT_ROTR: o_data = WIDTH'({i_data, i_data} >> i_k);
`endif
      default: o_data = i_data >> i_k;
    endcase
  end

endmodule

// File: rtl/iter_shift.sv
// Multi-cycle shifter: SLL/SRL/SRA (and ROTR with ITER_SHIFT_ROTATE_EN) by a runtime
// amount, STEP bits per cycle, with a start/ready/busy/done handshake.
module iter_shift
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP   = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  localparam int K_W = $clog2(STEP + 1);

  // Handshake: start is taken on a rising edge only while ready=1 (IDLE or DONE);
  // done is a one-cycle pulse and out then holds until the next accepted start.
  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_remaining;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_out;

  logic [K_W-1:0]   w_k;
  logic [WIDTH-1:0] w_shifted;
  logic             w_last;

  always_comb begin
    w_k = K_W'(STEP);
    if (r_remaining < AMT_W'(STEP)) w_k = K_W'(r_remaining);
  end

  assign w_last = (r_remaining == AMT_W'(w_k));

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .i_data (r_data),
    .i_mode (r_mode),
    .i_k    (w_k),
    .o_data (w_shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_remaining <= '0;
      r_mode      <= '0;
      r_out       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mode <= mode;
            r_data <= in;
            if (amt == '0) begin
              r_state     <= S_DONE;
              r_remaining <= '0;
              r_out       <= in;
            end else begin
              r_state     <= S_SHIFT;
              r_remaining <= amt;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_data      <= w_shifted;
          r_remaining <= r_remaining - AMT_W'(w_k);
          if (w_last) begin
            r_state <= S_DONE;
            r_out   <= w_shifted;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy  = (r_state == S_SHIFT);
  assign done  = (r_state == S_DONE);
  assign out   = r_out;

endmodule

// File: tb/tb_iter_shift.sv
// Directed bench for iter_shift: a STEP=1 and a STEP=4 instance, each with an expected
// queue of results and done cycles, drained by a monitor on the falling edge.
module tb_iter_shift;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // STEP=1 instance
  logic         a_start = 1'b0;
  logic [1:0]   a_mode  = 2'b00;
  logic [4:0]   a_amt   = '0;
  logic [W-1:0] a_in    = '0;
  logic         a_ready, a_busy, a_done;
  logic [W-1:0] a_out;

  iter_shift #(.WIDTH(W), .STEP(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .amt(a_amt), .in(a_in),
    .ready(a_ready), .busy(a_busy), .done(a_done), .out(a_out)
  );

  // STEP=4 instance
  logic         b_start = 1'b0;
  logic [1:0]   b_mode  = 2'b00;
  logic [4:0]   b_amt   = '0;
  logic [W-1:0] b_in    = '0;
  logic         b_ready, b_busy, b_done;
  logic [W-1:0] b_out;

  iter_shift #(.WIDTH(W), .STEP(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .amt(b_amt), .in(b_in),
    .ready(b_ready), .busy(b_busy), .done(b_done), .out(b_out)
  );

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] exp4_q[$];
  int           exp4_cyc_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every done pulse must match the head of its queue in value and cycle.
  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("a_spurious_done", 32'd1, 32'd0);
      end else begin
        chk("a_out", a_out, exp_q.pop_front());
        chk("a_done_cycle", W'(cyc), W'(exp_cyc_q.pop_front()));
      end
    end
    if (b_done === 1'b1) begin
      if (exp4_q.size() == 0) begin
        chk("b_spurious_done", 32'd1, 32'd0);
      end else begin
        chk("b_out", b_out, exp4_q.pop_front());
        chk("b_done_cycle", W'(cyc), W'(exp4_cyc_q.pop_front()));
      end
    end
  end

  // Called at a falling edge; start is held across one rising edge and the task
  // returns at the following falling edge.
  task automatic issue_a(input logic [1:0] m, input int amount, input logic [W-1:0] d,
                         input logic [W-1:0] exp_out);
    chk("a_ready_at_issue", W'(a_ready), 32'd1);
    a_start = 1'b1; a_mode = m; a_amt = 5'(amount); a_in = d;
    exp_q.push_back(exp_out);
    exp_cyc_q.push_back(cyc + 1 + amount);
    @(negedge clk);
    a_start = 1'b0; a_in = 32'hDEAD_BEEF; a_amt = 5'd17; a_mode = 2'b11;
  endtask

  task automatic issue_b(input logic [1:0] m, input int amount, input logic [W-1:0] d,
                         input logic [W-1:0] exp_out);
    chk("b_ready_at_issue", W'(b_ready), 32'd1);
    b_start = 1'b1; b_mode = m; b_amt = 5'(amount); b_in = d;
    exp4_q.push_back(exp_out);
    exp4_cyc_q.push_back(cyc + 1 + (amount + 3) / 4);
    @(negedge clk);
    b_start = 1'b0; b_in = 32'hCAFE_F00D; b_amt = 5'd9; b_mode = 2'b00;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp4_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp4_q.size() != 0) begin
      chk({name, "_timeout"}, W'(exp_q.size() + exp4_q.size()), 32'd0);
      exp_q.delete(); exp_cyc_q.delete(); exp4_q.delete(); exp4_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  logic [W-1:0] rot1_exp, rot7_exp;

  initial begin
`ifdef ITER_SHIFT_ROTATE_EN
    rot1_exp = 32'h8000_0000;
    rot7_exp = 32'h0200_0000;
`else
    rot1_exp = 32'h0000_0000;
    rot7_exp = 32'h0000_0000;
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", W'(a_ready), 32'd1);
    chk("rst_busy", W'(a_busy), 32'd0);
    chk("rst_done", W'(a_done), 32'd0);
    chk("rst_out", a_out, 32'h0);
    chk("rst_out_b", b_out, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // SLL by 2: busy for two cycles, then done
    issue_a(2'b00, 2, 32'h0000_0003, 32'h0000_000C);
    chk("sll2_busy1", W'(a_busy), 32'd1);
    @(negedge clk);
    chk("sll2_busy2", W'(a_busy), 32'd1);
    drain("sll2", 10);

    issue_a(2'b10, 4, 32'h8000_00F0, 32'hF800_000F);
    drain("sra4", 20);
    issue_a(2'b01, 4, 32'h8000_00F0, 32'h0800_000F);
    drain("srl4", 20);
    issue_a(2'b10, 31, 32'h8000_0000, 32'hFFFF_FFFF);
    drain("sra31", 50);

    // Zero amount, then back-to-back start in the DONE cycle
    issue_a(2'b00, 0, 32'h1234_5678, 32'h1234_5678);
    chk("zero_done_cycle_ready", W'(a_done & a_ready), 32'd1);
    issue_a(2'b00, 1, 32'h1234_5678, 32'h2468_ACF0);
    drain("b2b", 10);

    // Starts during SHIFT are ignored
    issue_a(2'b00, 31, 32'h0000_0001, 32'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      repeat (3) @(negedge clk);
      chk("ign_busy", W'(a_busy), 32'd1);
      a_start = 1'b1; a_mode = 2'b01; a_amt = 5'd1; a_in = 32'hFFFF_FFFF;
      @(negedge clk);
      a_start = 1'b0;
    end
    drain("ign", 60);

    // Reset mid-SHIFT: back to idle, out cleared, no done
    issue_a(2'b01, 20, 32'hFFFF_0000, 32'h0000_0FFF);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete(); exp_cyc_q.delete();
    chk("abort_ready", W'(a_ready), 32'd1);
    chk("abort_busy", W'(a_busy), 32'd0);
    chk("abort_done", W'(a_done), 32'd0);
    chk("abort_out", a_out, 32'h0);
    // rst and start together: reset wins
    a_start = 1'b1; a_amt = 5'd3; a_in = 32'h1;
    @(negedge clk);
    a_start = 1'b0; rst = 1'b0;
    chk("rst_start_busy", W'(a_busy), 32'd0);
    chk("rst_start_done", W'(a_done), 32'd0);
    repeat (25) @(negedge clk);

    // Rotate (or SRL fallback) on both step sizes
    issue_a(2'b11, 1, 32'h0000_0001, rot1_exp);
    drain("rotr1", 10);
    issue_b(2'b11, 7, 32'h0000_0001, rot7_exp);
    drain("rotr7_s4", 10);
    issue_b(2'b00, 31, 32'h0000_0001, 32'h8000_0000);
    drain("sll31_s4", 20);
    issue_b(2'b10, 5, 32'h8000_0000, 32'hFC00_0000);
    drain("sra5_s4", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iter_shift.md
Name: iter_shift

Overview:
- Parametrised multi-cycle shift unit that generalises the fixed left-shift-by-2 branch-offset logic into a general shifter.
- Performs SLL/SRL/SRA (and optionally ROTR) by a runtime amount, STEP bit positions per clock.
- Uses a start/done handshake.
- Sits beside the ALU in the multi-cycle datapath for shift instructions (sll/srl/sra and variable forms); the control FSM stalls on busy.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two, ≥4.
- STEP, 1, bit positions shifted per SHIFT cycle; power of two, 1 ≤ STEP ≤ WIDTH/2.
- AMT_W, $clog2(WIDTH), local parameter, not overridable; width of the shift-amount field.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- mode  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROTR
- amt  input  AMT_W  shift amount, 0..WIDTH-1
- in  input  WIDTH  operand
- ready  output  1  unit can accept start this cycle
- busy  output  1  operation in progress (state SHIFT)
- done  output  1  one-cycle pulse: out valid
- out  output  WIDTH  result; held stable until the next accepted start

Behaviour:
- FSM states: IDLE, SHIFT, DONE.
- ready = (state==IDLE || state==DONE); busy = (state==SHIFT); done = (state==DONE).
- Reset: state=IDLE, out=0, internal data/remaining/mode registers=0; ready=1, busy=0, done=0.
- Acceptance: start sampled at a rising edge while ready=1.
  - mode, amt and in are latched into internal registers; data register = in.
  - If amt==0: next state DONE; out = in.
  - Otherwise: next state SHIFT; remaining = amt.
- SHIFT, each cycle: k = min(STEP, remaining).
  - Data register is shifted by k per latched mode: SLL fills with zeros at the LSB; SRL fills with zeros at the MSB; SRA replicates bit WIDTH-1; ROTR wraps LSBs into the MSBs.
  - remaining -= k.
  - When remaining reaches 0: next state DONE; out is loaded with the final shifted value on the same edge.
- DONE lasts exactly one cycle, then IDLE, unless start=1, in which case the new operation is accepted (back-to-back; done stays high only for that one cycle).
- Latency: done asserted in cycle a+1+ceil(amt/STEP), where a is the acceptance cycle. WIDTH=32, STEP=1, amt=31 → done 32 cycles after acceptance.
- start while busy=1 is ignored; no queuing, no effect on the operation in flight.
- Input changes after acceptance have no effect.
- rst asserted mid-SHIFT: next edge returns to IDLE, out=0, no done pulse.
- rst and start in the same cycle: rst wins.
- Arithmetic: amt is interpreted unsigned and is never ≥ WIDTH by construction (AMT_W bits).
- out changes only on the edge entering DONE (or on reset).

Optional Feature:
- Macro ITER_SHIFT_ROTATE_EN.
- Defined: mode 11 performs rotate-right as described.
- Undefined: the rotate datapath is not built; mode 11 behaves exactly as SRL (zero fill); timing and handshake are unchanged.

Decomposition:
- Shared package shift_pkg:
  - mode encoding constants SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROTR=2'b11.
  - FSM state typedef (IDLE/SHIFT/DONE, 2-bit encoding).
  - The package is used by the control FSM decoder as well.
- One natural sub-module: shift_step, a combinational single-step shifter. Inputs: data, mode, k (0..STEP). Output: shifted data. The iteration FSM, counter and handshake stay in iter_shift.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → ready=1, busy=0, done=0, out=0x00000000.
- SLL by 2 (WIDTH=32, STEP=1): in=0x0000_0003, amt=2 → busy for 2 cycles, done in cycle a+3, out=0x0000_000C.
- SRA vs SRL by 4: in=0x8000_00F0, mode=10 → out=0xF800_000F; mode=01 → out=0x0800_000F.
- Zero amount and back-to-back: amt=0, in=0x1234_5678 → done at a+1, out=0x1234_5678. Start asserted during that DONE cycle with SLL amt=1 → accepted, done again at that acceptance cycle+2, out=0x2468_ACF0.
- Ignore and abort:
  - start pulses during SHIFT (amt=31) → no effect; done at a+32.
  - Separate run: rst mid-SHIFT → IDLE next cycle, out=0, no done pulse.
- ROTR / macro: in=0x0000_0001, mode=11, amt=1 → with ITER_SHIFT_ROTATE_EN out=0x8000_0000; without it out=0x0000_0000. Repeat with STEP=4, amt=7 → done at a+3 (2 SHIFT cycles).
